// File: rtl/alu_writeback.sv
// Purpose : ALU writeback stage. One-entry holding register feeding a 2**REG_AW x DATA_W
//           register file and a 4-bit status-flag register, plus two bypassed read ports.
// Latency : capture edge N, commit at the first later edge with stall=0 (N+1 when unstalled);
//           the held result is visible on the read ports right after the capture edge.
// Backpressure: in_ready = !hold_valid || !stall; it never depends on in_valid.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           capture handshake for in_result/in_rd/in_we/in_flags_we/flag_*
//   stall                       downstream hold; blocks commit of the held entry
//   rs1_addr/rs1_data, rs2_*    combinational read ports with writeback bypass
//   status_flags                architectural flags {neg, parity, overflow, carry}
//   wb_valid/wb_rd/wb_data      registered commit pulse and committed register/data
//   commit_count                commits since reset, wraps at 2**CNT_W
module alu_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_flags_we,
    input  logic              flag_carry,
    input  logic              flag_overflow,
    input  logic              flag_parity,
    input  logic              flag_neg,
    input  logic              stall,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [3:0]        status_flags,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  commit_count
);

    localparam int NREG = 1 << REG_AW;

    // holding register
    logic              hold_valid;
    logic [DATA_W-1:0] hold_result;
    logic [REG_AW-1:0] hold_rd;
    logic              hold_we;
    logic              hold_flags_we;
    logic [3:0]        hold_flags;

    logic [DATA_W-1:0] rf [NREG];

    logic capture;
    logic commit;
    logic rf_wr;

    assign in_ready = !hold_valid || !stall;
    assign capture  = in_valid && in_ready;
    assign commit   = hold_valid && !stall;
    // register 0 is hard-wired to zero, so writes to it are dropped
    assign rf_wr    = commit && hold_we && (hold_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid    <= 1'b0;
            hold_result   <= '0;
            hold_rd       <= '0;
            hold_we       <= 1'b0;
            hold_flags_we <= 1'b0;
            hold_flags    <= '0;
            status_flags  <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            commit_count  <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            // a commit and a capture on the same edge leave the register full
            if (capture) begin
                hold_valid    <= 1'b1;
                hold_result   <= in_result;
                hold_rd       <= in_rd;
                hold_we       <= in_we;
                hold_flags_we <= in_flags_we;
                hold_flags    <= {flag_neg, flag_parity, flag_overflow, flag_carry};
            end else if (commit) begin
                hold_valid <= 1'b0;
            end

            wb_valid <= commit;
            if (commit) begin
                wb_rd        <= hold_rd;
                wb_data      <= hold_result;
                commit_count <= commit_count + CNT_W'(1);
                if (hold_flags_we) begin
                    status_flags <= hold_flags;
                end
            end

            if (rf_wr) begin
                rf[hold_rd] <= hold_result;
            end
        end
    end

    // read ports: zero register first, then the not-yet-committed held result, then the file
    always_comb begin
        rs1_data = rf[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (hold_valid && hold_we && (hold_rd == rs1_addr)) begin
            rs1_data = hold_result;
        end
    end

    always_comb begin
        rs2_data = rf[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (hold_valid && hold_we && (hold_rd == rs2_addr)) begin
            rs2_data = hold_result;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;   // narrow counter so wrap-around is reachable quickly

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [AW-1:0] in_rd;
    logic          in_we;
    logic          in_flags_we;
    logic          flag_carry, flag_overflow, flag_parity, flag_neg;
    logic          stall;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [DW-1:0] rs1_data, rs2_data;
    logic [3:0]    status_flags;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [CW-1:0] commit_count;

    always #5 clk = ~clk;

    alu_writeback #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd(in_rd), .in_we(in_we), .in_flags_we(in_flags_we),
        .flag_carry(flag_carry), .flag_overflow(flag_overflow),
        .flag_parity(flag_parity), .flag_neg(flag_neg),
        .stall(stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .status_flags(status_flags),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .commit_count(commit_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] res;
        int            rd;
        bit            we;
        bit            fwe;
        logic [3:0]    fl;
    } ent_t;

    ent_t          pend[$];          // entries captured but not yet committed
    logic [DW-1:0] m_rf [32];
    logic [3:0]    m_flags;
    int            m_cnt;
    bit            m_wbv;
    int            m_wbrd;
    logic [DW-1:0] m_wbd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (pend.size() > 0 && pend[0].we && pend[0].rd == a) return pend[0].res;
        return m_rf[a];
    endfunction

    function automatic void m_clear();
        pend.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_flags = '0;
        m_cnt   = 0;
        m_wbv   = 0;
        m_wbrd  = 0;
        m_wbd   = '0;
    endfunction

    // one clock: check outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        bit   ready, cap, com;
        ent_t e;
        @(negedge clk);
        ready = (pend.size() == 0) || !stall;
        check_eq("in_ready", in_ready, ready);
        check_eq("rs1_data", rs1_data, m_read(int'(rs1_addr)));
        check_eq("rs2_data", rs2_data, m_read(int'(rs2_addr)));
        check_eq("status_flags", status_flags, m_flags);
        check_eq("wb_valid", wb_valid, m_wbv);
        if (m_wbv) begin
            check_eq("wb_rd", wb_rd, m_wbrd);
            check_eq("wb_data", wb_data, m_wbd);
        end
        check_eq("commit_count", commit_count, m_cnt);
        cap = in_valid && ready;
        com = (pend.size() != 0) && !stall;
        e.res = in_result;
        e.rd  = int'(in_rd);
        e.we  = in_we;
        e.fwe = in_flags_we;
        e.fl  = {flag_neg, flag_parity, flag_overflow, flag_carry};
        @(posedge clk);
        if (!rst_n) begin
            m_clear();
        end else begin
            m_wbv = 0;
            if (com) begin
                ent_t c;
                c = pend.pop_front();
                if (c.we && c.rd != 0) m_rf[c.rd] = c.res;
                if (c.fwe) m_flags = c.fl;
                m_cnt  = (m_cnt + 1) % (1 << CW);
                m_wbv  = 1;
                m_wbrd = c.rd;
                m_wbd  = c.res;
            end
            if (cap) pend.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input int rd, input logic [DW-1:0] res, input bit we,
                         input bit fwe, input logic [3:0] fl, input bit st);
        in_valid      = v;
        in_rd         = AW'(rd);
        in_result     = res;
        in_we         = we;
        in_flags_we   = fwe;
        flag_neg      = fl[3];
        flag_parity   = fl[2];
        flag_overflow = fl[1];
        flag_carry    = fl[0];
        stall         = st;
    endtask

    task automatic idle(input bit st);
        drive(0, 0, '0, 0, 0, 4'b0000, st);
    endtask

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        idle(0);
        repeat (2) @(posedge clk);
        m_clear();
        #1;
        rst_n = 1'b1;

        // reset state: every register reads zero
        for (int a = 1; a < 32; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(32 - a);
            cycle();
        end
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_flags", status_flags, 0);
        check_eq("rst_count", commit_count, 0);

        // r5 = DEADBEEF with flags c=1 o=0 p=1 n=0
        rs1_addr = 5;
        drive(1, 5, 32'hDEADBEEF, 1, 1, 4'b0101, 0);
        cycle();
        idle(0);
        check_eq("r5_bypass", rs1_data, 32'hDEADBEEF);
        check_eq("r5_flags_not_yet", status_flags, 0);
        cycle();
        check_eq("r5_rf", rs1_data, 32'hDEADBEEF);
        check_eq("r5_flags", status_flags, 4'b0101);
        check_eq("r5_wb_valid", wb_valid, 1);
        check_eq("r5_wb_rd", wb_rd, 5);
        check_eq("r5_count", commit_count, 1);
        cycle();
        check_eq("r5_wb_pulse_end", wb_valid, 0);

        // back-to-back r1..r4 = 1..4
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, DW'(i), 1, 0, 4'b0000, 0);
            rs1_addr = AW'(i);
            cycle();
        end
        idle(0);
        for (int i = 1; i <= 4; i++) begin
            rs1_addr = AW'(i);
            cycle();
            check_eq("b2b_read", rs1_data, DW'(i));
        end
        check_eq("b2b_count", commit_count, 5);

        // r7 = 0x55 captured, then 3 stalled cycles with a competing request
        rs1_addr = 7;
        drive(1, 7, 32'h55, 1, 1, 4'b1111, 1);
        cycle();
        drive(1, 7, 32'hAA, 1, 1, 4'b1010, 1);
        repeat (3) begin
            cycle();
            check_eq("stall_ready", in_ready, 0);
            check_eq("stall_bypass", rs1_data, 32'h55);
            check_eq("stall_no_wb", wb_valid, 0);
        end
        idle(0);
        cycle();
        check_eq("stall_commit", wb_valid, 1);
        check_eq("stall_flags", status_flags, 4'b1111);
        cycle();

        // writes to r0 are dropped but still commit
        rs1_addr = 0;
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 4'b0000, 0);
        cycle();
        idle(0);
        check_eq("r0_held", rs1_data, 0);
        cycle();
        check_eq("r0_after", rs1_data, 0);
        check_eq("r0_wb_valid", wb_valid, 1);
        cycle();

        // counter wrap: 20 back-to-back commits
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom_range(0, 31), $urandom, 1, 0, 4'b0000, 0);
            rs1_addr = AW'($urandom_range(0, 31));
            cycle();
        end
        idle(0);
        cycle();
        cycle();

        // reset while stalled with r9 held
        rs1_addr = 9;
        drive(1, 9, 32'h1234, 1, 1, 4'b0011, 0);
        cycle();
        drive(1, 9, 32'h9999, 1, 1, 4'b1100, 1);
        cycle();
        idle(1);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("rst_stall_r9", rs1_data, 0);
        check_eq("rst_stall_wb", wb_valid, 0);
        check_eq("rst_stall_flags", status_flags, 0);
        check_eq("rst_stall_ready", in_ready, 1);
        idle(0);
        cycle();
        cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 3) == 0);
            rst_n    = ($urandom_range(0, 199) != 0);
            rs1_addr = (pend.size() > 0 && $urandom_range(0, 1) == 1) ? AW'(pend[0].rd)
                                                                      : AW'($urandom_range(0, 31));
            rs2_addr = AW'($urandom_range(0, 31));
            cycle();
        end
        rst_n = 1'b1;
        idle(0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
